multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset processor; it sequences the shared datapath (one memory, one ALU, instruction/data registers) over 3-5 cycles per instruction.
- Contains four pieces:
  - the main FSM;
  - the ALU-control decode;
  - the condition-check logic, with the registered NZCV flags;
  - PC-write logic.
- Inputs are the instruction fields held in the instruction register and the ALU flags. Outputs are all datapath enables and mux selects.

Parameters:
- None. The state encoding is fixed, as listed under Behaviour.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- Cond  input  4  Instr[31:28]
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]
- Rd  input  4  Instr[15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  memory write enable
- RegWrite  output  1  register-file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  output  1  0=A (Rn), 1=PC
- ALUSrcB  output  2  00=WriteData (Rm), 01=ExtImm, 10=constant 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  output  2  equal to Op
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01); combinational
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- State  output  4  current FSM state, for debug

Behaviour:

State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Codes 10-15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH goes to DECODE.
- DECODE branches on the opcode:
  - Op=01 goes to MEMADR.
  - Op=00 with Funct[5]=0 goes to EXECUTER.
  - Op=00 with Funct[5]=1 goes to EXECUTEI.
  - Op=10 goes to BRANCH.
  - Op=11 goes to FETCH, with no side effects.
- MEMADR goes to MEMREAD if Funct[0]=1, otherwise to MEMWRITE.
- MEMREAD goes to MEMWB, then to FETCH.
- MEMWRITE goes to FETCH.
- EXECUTER and EXECUTEI go to ALUWB, then to FETCH.
- BRANCH goes to FETCH.

Per-state controls (unlisted signals are 0):
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.

ALU decode:
- ALUOp=0 gives ALUControl=00, NoWrite=0 and FlagW=00.
- ALUOp=1 decodes Funct[4:1]:
  - 0100 ADD gives 00.
  - 0010 SUB gives 01.
  - 0000 AND gives 10.
  - 1100 ORR gives 11.
  - 1010 CMP gives 01 with NoWrite=1.
  - Any other value gives 00 and is treated as ADD.
- FlagW[1] (writes N,Z) = Funct[0].
- FlagW[0] (writes C,V) = Funct[0] AND the operation is ADD, SUB or CMP.

Condition logic:
- CondEx is computed from Cond and the registered Flags.
- Supported codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE; AL=1110 gives 1; 1111 gives 0.
- CondExL is a register loaded with CondEx at the end of DECODE. All later states use CondExL.
- Flags are updated only in EXECUTER and EXECUTEI:
  - N,Z take ALUFlags[3:2] when FlagW[1] AND CondExL.
  - C,V take ALUFlags[1:0] when FlagW[0] AND CondExL.

Gated outputs:
- PCS = (Rd==15 AND RegW) OR Branch.
- PCWrite = NextPC OR (PCS AND CondExL).
- RegWrite = RegW AND CondExL AND NOT NoWrite.
  - NoWrite is registered alongside CondExL at the end of DECODE.
- MemWrite = MemW AND CondExL.

Reset:
- State=FETCH, Flags=0000, CondExL=1, NoWrite=0.
- The cycle after reset therefore presents the FETCH controls: IRWrite=1, PCWrite=1, all other enables 0.
- Reset asserted mid-instruction abandons the instruction. The next cycle is FETCH, and no MemWrite or RegWrite is issued.

Latencies:
- Branch: 3 cycles.
- Data-processing and STR: 4 cycles.
- LDR: 5 cycles.

Test Plan:
- ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000) -> State 0,1,6,8,0; ALUControl=00 in state 6; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- LDR (Op=01, Funct=011001) -> State 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB.
- STR (Funct=011000) -> State 0,1,2,5,0; MemWrite=1 for exactly one cycle; RegSrc=10.
- CMP immediate (Funct=110101) with ALUFlags=0100 -> Flags become 0100; RegWrite=0 in ALUWB.
  - Following BEQ (Cond=0000, Op=10) -> PCWrite=1 in BRANCH.
  - BNE (Cond=0001) instead -> PCWrite=0 in BRANCH.
- ADD with Rd=15 -> PCWrite=1 and RegWrite=1 in ALUWB. With Cond=0000 and Z=0, both are 0.
- reset=1 during MEMWRITE -> next cycle State=0, MemWrite=0, Flags=0000.
  - Op=11 -> State 0,1,0 with no enables asserted in DECODE.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM-subset datapath: main FSM, ALU decode,
// condition check with NZCV flags, and PC/register/memory write gating.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4
  // DECODE   | read registers, compute PC+8, latch condition result
  // MEMADR   | compute load/store address
  // MEMREAD  | read data memory
  // MEMWB    | write loaded data to register file
  // MEMWRITE | write data memory
  // EXECUTER | ALU op with register operand
  // EXECUTEI | ALU op with immediate operand
  // ALUWB    | write ALU result to register file
  // BRANCH   | compute branch target, write PC
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  state_t     state;
  state_t     state_nx;
  ctrl_t      ctrl;
  logic [3:0] flags;
  logic       condexl;
  logic       nowrite_l;
  logic       condex;
  logic       nowrite_dec;
  logic       arith;
  logic [1:0] alucontrol_d;
  logic [1:0] flagw;
  logic       pcs;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.nextpc    = 1'b1;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_MEMADR:   c.alusrcb = 2'b01;
      S_MEMREAD:  c.adrsrc  = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regw      = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      S_EXECUTER: c.aluop = 1'b1;
      S_EXECUTEI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 1'b1;
      end
      S_ALUWB:    c.regw = 1'b1;
      S_BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.branch    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_nx = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_nx = S_MEMADR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nx = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nx = S_MEMWB;
      S_EXECUTER: state_nx = S_ALUWB;
      S_EXECUTEI: state_nx = S_ALUWB;
      default:    state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol_d = 2'b00;
    arith        = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alucontrol_d = 2'b00; arith = 1'b1; end
      4'b0010: begin alucontrol_d = 2'b01; arith = 1'b1; end
      4'b0000: alucontrol_d = 2'b10;
      4'b1100: alucontrol_d = 2'b11;
      4'b1010: begin alucontrol_d = 2'b01; arith = 1'b1; end
      default: alucontrol_d = 2'b00;
    endcase
  end

  // NoWrite is latched in DECODE, before ALUOp is active, so decode it from the opcode directly
  assign nowrite_dec = (Op == 2'b00) && (Funct[4:1] == 4'b1010);
  assign ALUControl  = ctrl.aluop ? alucontrol_d : 2'b00;
  assign flagw       = ctrl.aluop ? {Funct[0], Funct[0] & arith} : 2'b00;

  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = flags[2];
      4'b0001: condex = ~flags[2];
      4'b0010: condex = flags[1];
      4'b0011: condex = ~flags[1];
      4'b0100: condex = flags[3];
      4'b0101: condex = ~flags[3];
      4'b0110: condex = flags[0];
      4'b0111: condex = ~flags[0];
      4'b1000: condex = flags[1] & ~flags[2];
      4'b1001: condex = ~flags[1] | flags[2];
      4'b1010: condex = (flags[3] == flags[0]);
      4'b1011: condex = (flags[3] != flags[0]);
      4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condex = flags[2] | (flags[3] != flags[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Controls are registered from the next state so they line up with State
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ctrl      <= ctrl_of(S_FETCH);
      flags     <= 4'b0000;
      condexl   <= 1'b1;
      nowrite_l <= 1'b0;
    end else begin
      state <= state_nx;
      ctrl  <= ctrl_of(state_nx);
      if (state == S_DECODE) begin
        condexl   <= condex;
        nowrite_l <= nowrite_dec;
      end
      if ((state == S_EXECUTER) || (state == S_EXECUTEI)) begin
        if (flagw[1] && condexl) flags[3:2] <= ALUFlags[3:2];
        if (flagw[0] && condexl) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign pcs       = ((Rd == 4'd15) && ctrl.regw) || ctrl.branch;
  assign PCWrite   = ctrl.nextpc | (pcs & condexl);
  assign RegWrite  = ctrl.regw & condexl & ~nowrite_l;
  assign MemWrite  = ctrl.memw & condexl;
  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ImmSrc    = Op;
  assign RegSrc    = {(Op == 2'b01), (Op == 2'b10)};
  assign State     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequences with
// hand-computed state walks, gated enables and flag-dependent branches.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_instr(4'hE, 2'b11, 6'd0, 4'd0);
    ALUFlags = 4'b0000;
    tick; tick;
    reset = 1'b0;
    n_checks++;
    if (State !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", State);
    end
    n_checks++;
    if ({IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 10'b1100011010) begin
      n_fail++;
      $display("FAIL reset_controls: got %b expected 1100011010",
               {IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    end
  endtask

  // Data-processing instruction: FETCH, DECODE, EXECUTE(R/I), ALUWB, FETCH
  task automatic test_dp(input string name, input logic [3:0] c, input logic [5:0] f,
                         input logic [3:0] r, input logic [3:0] fl, input logic [3:0] exe,
                         input logic [1:0] exp_ac, input logic exp_rw, input logic exp_pw);
    logic [3:0] seq [0:4];
    logic       pw, rw;
    seq = '{4'd0, 4'd1, exe, 4'd8, 4'd0};
    set_instr(c, 2'b00, f, r);
    ALUFlags = fl;
    for (int i = 0; i < 5; i++) begin
      pw = (i == 0 || i == 4) ? 1'b1 : ((i == 3) ? exp_pw : 1'b0);
      rw = (i == 3) ? exp_rw : 1'b0;
      n_checks++;
      if (State !== seq[i]) begin
        n_fail++; $display("FAIL %s cyc%0d State: got %0d expected %0d", name, i, State, seq[i]);
      end
      n_checks++;
      if (PCWrite !== pw) begin
        n_fail++; $display("FAIL %s cyc%0d PCWrite: got %b expected %b", name, i, PCWrite, pw);
      end
      n_checks++;
      if (RegWrite !== rw) begin
        n_fail++; $display("FAIL %s cyc%0d RegWrite: got %b expected %b", name, i, RegWrite, rw);
      end
      if (i == 2) begin
        n_checks++;
        if (ALUControl !== exp_ac) begin
          n_fail++; $display("FAIL %s ALUControl: got %b expected %b", name, ALUControl, exp_ac);
        end
        n_checks++;
        if ({ALUSrcA, ALUSrcB} !== {1'b0, (exe == 4'd7) ? 2'b01 : 2'b00}) begin
          n_fail++; $display("FAIL %s srcsel: got %b%b", name, ALUSrcA, ALUSrcB);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (ALUControl !== 2'b00) begin
          n_fail++; $display("FAIL %s decode ALUControl: got %b expected 00", name, ALUControl);
        end
      end
      if (i < 4) tick;
    end
  endtask

  task automatic test_branch(input string name, input logic [3:0] c, input logic taken);
    logic [3:0] seq [0:3];
    logic       pw;
    seq = '{4'd0, 4'd1, 4'd9, 4'd0};
    set_instr(c, 2'b10, 6'b000000, 4'd0);
    ALUFlags = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      pw = (i == 0 || i == 3) ? 1'b1 : ((i == 2) ? taken : 1'b0);
      n_checks++;
      if (State !== seq[i]) begin
        n_fail++; $display("FAIL %s cyc%0d State: got %0d expected %0d", name, i, State, seq[i]);
      end
      n_checks++;
      if (PCWrite !== pw) begin
        n_fail++; $display("FAIL %s cyc%0d PCWrite: got %b expected %b", name, i, PCWrite, pw);
      end
      n_checks++;
      if ({MemWrite, RegWrite} !== 2'b00) begin
        n_fail++; $display("FAIL %s cyc%0d writes: got %b%b expected 00", name, i, MemWrite, RegWrite);
      end
      if (i == 2) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc} !== 9'b0_01_10_10_01) begin
          n_fail++;
          $display("FAIL %s branch ctrl: got %b expected 001101001", name,
                   {ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc});
        end
      end
      if (i < 3) tick;
    end
  endtask

  task automatic test_ldr;
    logic [3:0] seq [0:5];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    set_instr(4'hE, 2'b01, 6'b011001, 4'd2);
    ALUFlags = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (State !== seq[i]) begin
        n_fail++; $display("FAIL ldr cyc%0d State: got %0d expected %0d", i, State, seq[i]);
      end
      n_checks++;
      if (AdrSrc !== (i == 3)) begin
        n_fail++; $display("FAIL ldr cyc%0d AdrSrc: got %b", i, AdrSrc);
      end
      n_checks++;
      if ({RegWrite, MemWrite} !== {(i == 4), 1'b0}) begin
        n_fail++; $display("FAIL ldr cyc%0d RegWrite/MemWrite: got %b%b", i, RegWrite, MemWrite);
      end
      if (i == 4) begin
        n_checks++;
        if (ResultSrc !== 2'b01) begin
          n_fail++; $display("FAIL ldr ResultSrc: got %b expected 01", ResultSrc);
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ImmSrc, RegSrc} !== 7'b0_01_01_10) begin
          n_fail++; $display("FAIL ldr memadr ctrl: got %b expected 0010110", {ALUSrcA, ALUSrcB, ImmSrc, RegSrc});
        end
      end
      if (i < 5) tick;
    end
  endtask

  task automatic test_str;
    logic [3:0] seq [0:4];
    seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    set_instr(4'hE, 2'b01, 6'b011000, 4'd4);
    ALUFlags = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (State !== seq[i]) begin
        n_fail++; $display("FAIL str cyc%0d State: got %0d expected %0d", i, State, seq[i]);
      end
      n_checks++;
      if ({MemWrite, AdrSrc, RegWrite} !== {(i == 3), (i == 3), 1'b0}) begin
        n_fail++; $display("FAIL str cyc%0d MemWrite/AdrSrc/RegWrite: got %b%b%b", i, MemWrite, AdrSrc, RegWrite);
      end
      n_checks++;
      if (RegSrc !== 2'b10) begin
        n_fail++; $display("FAIL str cyc%0d RegSrc: got %b expected 10", i, RegSrc);
      end
      if (i < 4) tick;
    end
  endtask

  task automatic test_reset_mid;
    set_instr(4'hE, 2'b01, 6'b011000, 4'd4);
    tick; tick; tick;
    n_checks++;
    if ({State, MemWrite} !== {4'd5, 1'b1}) begin
      n_fail++; $display("FAIL rstmid pre: got State %0d MemWrite %b expected 5 1", State, MemWrite);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_checks++;
    if (State !== 4'd0) begin
      n_fail++; $display("FAIL rstmid State: got %0d expected 0", State);
    end
    n_checks++;
    if ({MemWrite, RegWrite, PCWrite, IRWrite} !== 4'b0011) begin
      n_fail++; $display("FAIL rstmid enables: got %b expected 0011", {MemWrite, RegWrite, PCWrite, IRWrite});
    end
  endtask

  task automatic test_op11;
    logic [3:0] seq [0:2];
    seq = '{4'd0, 4'd1, 4'd0};
    set_instr(4'hE, 2'b11, 6'b000000, 4'd15);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (State !== seq[i]) begin
        n_fail++; $display("FAIL op11 cyc%0d State: got %0d expected %0d", i, State, seq[i]);
      end
      if (i == 1) begin
        n_checks++;
        if ({IRWrite, PCWrite, MemWrite, RegWrite} !== 4'b0000) begin
          n_fail++; $display("FAIL op11 decode enables: got %b expected 0000", {IRWrite, PCWrite, MemWrite, RegWrite});
        end
      end
      if (i < 2) tick;
    end
  endtask

  initial begin
    test_reset;
    // flags 0000; ADD without S must not touch flags
    test_dp("add",  4'hE, 6'b001000, 4'd1, 4'b0100, 4'd6, 2'b00, 1'b1, 1'b0);
    test_branch("beq_after_add", 4'b0000, 1'b0);
    test_ldr;
    test_str;
    test_dp("and",  4'hE, 6'b000000, 4'd3, 4'b0000, 4'd6, 2'b10, 1'b1, 1'b0);
    test_dp("orr",  4'hE, 6'b011000, 4'd3, 4'b0000, 4'd6, 2'b11, 1'b1, 1'b0);
    test_dp("sub",  4'hE, 6'b000100, 4'd3, 4'b0000, 4'd6, 2'b01, 1'b1, 1'b0);
    // CMP #imm with Z from ALU -> flags 0100
    test_dp("cmpi", 4'hE, 6'b110101, 4'd0, 4'b0100, 4'd7, 2'b01, 1'b0, 1'b0);
    test_branch("beq_taken", 4'b0000, 1'b1);
    test_branch("bne_not",   4'b0001, 1'b0);
    // SUBS with C from ALU -> flags 0010
    test_dp("subs", 4'hE, 6'b000101, 4'd5, 4'b0010, 4'd6, 2'b01, 1'b1, 1'b0);
    test_branch("bcs_taken", 4'b0010, 1'b1);
    test_branch("bhi_taken", 4'b1000, 1'b1);
    test_branch("bls_not",   4'b1001, 1'b0);
    // ANDS writes N,Z only -> flags 1010
    test_dp("ands", 4'hE, 6'b000001, 4'd5, 4'b1011, 4'd6, 2'b10, 1'b1, 1'b0);
    test_branch("bmi_taken", 4'b0100, 1'b1);
    test_branch("bvs_not",   4'b0110, 1'b0);
    test_branch("blt_taken", 4'b1011, 1'b1);
    // SUBSEQ with Z=0 is squashed: no write, no flag update
    test_dp("subseq_skip", 4'b0000, 6'b000101, 4'd5, 4'b0100, 4'd6, 2'b01, 1'b0, 1'b0);
    test_branch("beq_still_not", 4'b0000, 1'b0);
    test_dp("add_pc",    4'hE,    6'b001000, 4'd15, 4'b0000, 4'd6, 2'b00, 1'b1, 1'b1);
    test_dp("addeq_pc",  4'b0000, 6'b001000, 4'd15, 4'b0000, 4'd6, 2'b00, 1'b0, 1'b0);
    // reset clears flags (N was 1) and restores CondExL
    test_reset_mid;
    test_branch("bmi_after_rst", 4'b0100, 1'b0);
    test_dp("add_after_rst", 4'hE, 6'b001000, 4'd1, 4'b0000, 4'd6, 2'b00, 1'b1, 1'b0);
    test_op11;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
